// File: rtl/c17_bist_tpg.sv
// c17_bist_tpg: LFSR test pattern generator for the ISCAS c17 benchmark.
// Ports: clk, rst (sync, active-high), start, hold in; N1,N2,N3,N6,N7,
//   pat_valid, pat_idx[5:0], busy, done out.
module c17_bist_tpg #(
  parameter int         NUM_PAT  = 31,
  parameter logic [4:0] SEED     = 5'b00001,
  parameter bit         ZERO_PAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic       N1,
  output logic       N2,
  output logic       N3,
  output logic       N6,
  output logic       N7,
  output logic       pat_valid,
  output logic [5:0] pat_idx,
  output logic       busy,
  output logic       done
);

  if (SEED == 5'd0 || NUM_PAT < 1 || NUM_PAT > 31) begin : g_bad_param
    $error("c17_bist_tpg: SEED must be nonzero, NUM_PAT in 1..31");
  end

  localparam int LEN = NUM_PAT + (ZERO_PAT ? 1 : 0);
  localparam logic [5:0] LAST = 6'(LEN - 1);
  localparam logic [5:0] NP6  = 6'(NUM_PAT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [5:0] idx_q, idx_d;
  logic [4:0] lfsr_nxt;
  logic [4:0] pat;
  logic       run;

  assign lfsr_nxt = {s_q[3:0], s_q[4] ^ s_q[2]};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = SEED;
          idx_d   = 6'd0;
        end
      end
      RUN: begin
        if (!hold) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            s_d   = lfsr_nxt;
            idx_d = idx_q + 6'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= SEED;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
    end
  end

  // Past the LFSR patterns the register keeps shifting, so mask it:
  // that slot is the appended all-zero pattern.
  assign run = (state_q == RUN);
  assign pat = (run && idx_q < NP6) ? s_q : 5'd0;

  assign N1 = pat[4];
  assign N2 = pat[3];
  assign N3 = pat[2];
  assign N6 = pat[1];
  assign N7 = pat[0];

  assign pat_valid = run && !hold;
  assign pat_idx   = run ? idx_q : 6'd0;
  assign busy      = run;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_c17_bist_tpg.sv
// tb_c17_bist_tpg: randomized + directed bench for c17_bist_tpg,
// two instances (default and NUM_PAT=4/SEED=10000/no zero pattern).
module tb_c17_bist_tpg;

  logic clk = 1'b0;
  logic rst, start, hold;

  logic [4:0] n0, n1;
  logic       v0, v1, b0, b1, d0, d1;
  logic [5:0] x0, x1;

  int vectors = 0;
  int miscompares = 0;

  int ph [2];
  int k  [2];
  int np [2] = '{31, 4};
  int zp [2] = '{1, 0};
  logic [4:0] sd [2] = '{5'b00001, 5'b10000};

  int cnt_v0;
  logic [31:0] seen0;

  logic [4:0] lit36 [6] = '{5'b00001, 5'b00010, 5'b00100,
                            5'b01001, 5'b10010, 5'b00101};
  logic [4:0] lit40 [4] = '{5'b10000, 5'b00001, 5'b00010, 5'b00100};

  always #5 clk = ~clk;

  c17_bist_tpg u0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .N1(n0[4]), .N2(n0[3]), .N3(n0[2]), .N6(n0[1]), .N7(n0[0]),
    .pat_valid(v0), .pat_idx(x0), .busy(b0), .done(d0)
  );

  c17_bist_tpg #(.NUM_PAT(4), .SEED(5'b10000), .ZERO_PAT(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .N1(n1[4]), .N2(n1[3]), .N3(n1[2]), .N6(n1[1]), .N7(n1[0]),
    .pat_valid(v1), .pat_idx(x1), .busy(b1), .done(d1)
  );

  // i-th pattern of a run: i LFSR steps from the seed, zero beyond np
  function automatic logic [4:0] pat_of(logic [4:0] seed, int i, int n);
    logic [4:0] s;
    s = seed;
    if (i >= n) return 5'd0;
    repeat (i) s = {s[3:0], s[4] ^ s[2]};
    return s;
  endfunction

  function automatic logic [13:0] exp_out(int i);
    logic r;
    r = (ph[i] == 1);
    return {r, ph[i] == 2, r && !hold,
            r ? 6'(k[i]) : 6'd0,
            r ? pat_of(sd[i], k[i], np[i]) : 5'd0};
  endfunction

  function automatic logic [13:0] act(int i);
    if (i == 0) return {b0, d0, v0, x0, n0};
    return {b1, d1, v1, x1, n1};
  endfunction

  task automatic step(int i);
    if (rst) begin
      ph[i] = 0;
      k[i]  = 0;
    end else begin
      case (ph[i])
        0: if (start) begin ph[i] = 1; k[i] = 0; end
        1: if (!hold) begin
             if (k[i] == np[i] + zp[i] - 1) ph[i] = 2;
             else k[i]++;
           end
        default: ph[i] = 0;
      endcase
    end
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic h);
    rst = r; start = s; hold = h;
    #1;
    chk("dut0", 32'(act(0)), 32'(exp_out(0)));
    chk("dut1", 32'(act(1)), 32'(exp_out(1)));
    if (v0 === 1'b1) begin
      cnt_v0++;
      seen0[n0] = 1'b1;
    end
    @(posedge clk);
    step(0);
    step(1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin ph[i] = 0; k[i] = 0; end
    @(negedge clk);

    // model pinned against hand-derived values
    chk("mdl_p3", 32'(pat_of(5'b00001, 3, 31)), 32'h09);
    chk("mdl_p5", 32'(pat_of(5'b00001, 5, 31)), 32'h05);
    chk("mdl_z", 32'(pat_of(5'b00001, 31, 31)), 32'h00);

    // full default run, plus short run on u1
    tick(1, 0, 0);
    chk("rst_out", 32'({b0, d0, v0, x0, n0}), 32'h0);
    tick(0, 1, 0);
    cnt_v0 = 0; seen0 = '0;
    for (int c = 1; c <= 34; c++) begin
      if (c <= 6) begin
        chk("first_pat", 32'(n0), 32'(lit36[c-1]));
        chk("first_idx", 32'(x0), 32'(c - 1));
      end
      if (c <= 4) chk("short_pat", 32'(n1), 32'(lit40[c-1]));
      if (c == 5) chk("short_done", 32'(d1), 32'h1);
      if (c == 32) chk("last_zero", 32'({x0, n0}), 32'({6'd31, 5'd0}));
      if (c == 33) chk("run_end", 32'({d0, b0}), 32'h2);
      tick(0, 0, 0);
    end
    chk("valid_cnt", 32'(cnt_v0), 32'd32);
    chk("distinct", 32'($countones(seen0)), 32'd32);

    // hold on cycles 3..5
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int c = 1; c <= 36; c++) begin
      hold = (c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 6)
        chk("hold_pat", 32'({x0, n0}), 32'({6'd2, 5'b00100}));
      if (c >= 3 && c <= 5) chk("hold_v", 32'(v0), 32'h0);
      if (c == 6) chk("hold_rel_v", 32'(v0), 32'h1);
      if (c == 7) chk("hold_next", 32'({x0, n0}), 32'({6'd3, 5'b01001}));
      tick(0, 0, (c >= 3 && c <= 5));
    end

    // reset mid-run at cycle 10
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int c = 1; c <= 9; c++) tick(0, 0, 0);
    tick(1, 0, 0);
    chk("abort", 32'({b0, d0, v0, x0, n0}), 32'h0);
    tick(0, 1, 0);
    chk("restart", 32'({b0, n0}), 32'({1'b1, 5'b00001}));
    for (int c = 0; c < 40; c++) tick(0, 0, 0);

    // start during RUN at pat_idx 7
    tick(1, 0, 0);
    tick(0, 1, 0);
    cnt_v0 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 8) chk("idx7", 32'(x0), 32'd7);
      tick(0, (c == 8), 0);
    end
    chk("cnt_restart_ign", 32'(cnt_v0), 32'd32);

    // start held high: u1 re-runs two cycles after done
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) chk("held_done", 32'(d1), 32'h1);
      if (c == 7) chk("held_rerun", 32'({b1, n1}), 32'({1'b1, 5'b10000}));
      tick(0, 1, 0);
    end

    // reset during DONE of u1
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int c = 1; c <= 4; c++) tick(0, 0, 0);
    chk("done_pre", 32'(d1), 32'h1);
    tick(1, 0, 0);
    chk("done_rst", 32'(d1), 32'h0);

    // randomized
    for (int c = 0; c < 3000; c++)
      tick(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
